// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-path types and constants: FSM states, XLEN, PC step, reset PC default.
// Imported by the fetch top and its FIFO; holds no logic of its own.
package instruction_fetch_pkg;

  localparam int XLEN    = 32;
  localparam int PC_STEP = 4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_buffer.sv
// fetch_buffer: DEPTH-entry synchronous FIFO of T with push, pop, count and clear.
// Push lands next cycle; push into a full FIFO succeeds only alongside a pop; clear wins.
module fetch_buffer
  import instruction_fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter int  CW    = $clog2(DEPTH + 1),
  parameter type T     = fetch_entry_t
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;
  logic          empty, full;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == DEPTH_C);
  assign count = cnt_q;
  assign head  = mem_q[rd_q];

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    if (clear) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_data;
        wr_d = (wr_q == LAST) ? '0 : wr_q + PW'(1);
      end
      if (do_pop) begin
        rd_d = (rd_q == LAST) ? '0 : rd_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: in-order request/response pairing, credit-limited to DEPTH slots, redirect flush.
// Response reaches decode the cycle after it arrives; decode stall stops new requests once slots run out.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]   aq_count, buf_count;
  logic [XLEN-1:0] aq_head;
  fetch_entry_t    buf_head, rsp_entry;
  logic [CW:0]     in_use;
  logic            req_valid, req_fire, id_pop, aq_pop, buf_push;

  assign imem_addr      = align_pc(pc_q);
  assign imem_req_valid = req_valid;
  assign id_valid       = (buf_count != '0);
  assign id_pc          = buf_head.pc;
  assign id_instr       = buf_head.instr;
  assign rsp_entry      = '{pc: aq_head, instr: imem_rsp_data};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    aq_pop     = 1'b0;
    buf_push   = 1'b0;
    id_pop     = id_valid && id_ready;
    // A slot freed by this cycle's decode pop can be re-credited immediately.
    in_use     = {1'b0, aq_count} + {1'b0, buf_count} - {{CW{1'b0}}, id_pop};
    req_valid  = !rst && (state_q == FETCH) && !redirect_valid && (in_use < DEPTH_W);
    req_fire   = req_valid && imem_req_ready;

    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
    end else if (req_fire) begin
      pc_d = pc_q + XLEN'(PC_STEP);
    end

    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          // A response landing in the redirect cycle is already answered, so not counted as stale.
          drop_cnt_d = aq_count - CW'(imem_rsp_valid);
          if (drop_cnt_d != '0) begin
            state_d = FLUSH;
          end
        end else if (imem_rsp_valid) begin
          aq_pop   = 1'b1;
          buf_push = 1'b1;
        end
      end
      FLUSH: begin
        if (imem_rsp_valid) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
          if (drop_cnt_q == CW'(1)) begin
            state_d = FETCH;
          end
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH),
    .CW    (CW),
    .T     (logic [XLEN-1:0])
  ) u_addr_q (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (req_fire),
    .push_data (imem_addr),
    .pop       (aq_pop),
    .head      (aq_head),
    .count     (aq_count)
  );

  fetch_buffer #(
    .DEPTH (DEPTH),
    .CW    (CW),
    .T     (fetch_entry_t)
  ) u_instr_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (buf_push),
    .push_data (rsp_entry),
    .pop       (id_pop),
    .head      (buf_head),
    .count     (buf_count)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic against a queue-based model.
// A second instance with a wrapping reset PC streams freely alongside.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam int          DEPTH      = 2;
  localparam logic [31:0] W_RESET_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold_rst;
  always #5 clk = ~clk;

  logic        imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid, id_valid, id_ready;
  logic [31:0] imem_addr, imem_rsp_data, redirect_pc, id_instr, id_pc;

  logic        w_req_valid, w_req_ready, w_rsp_valid, w_redirect_valid, w_id_valid, w_id_ready;
  logic [31:0] w_addr, w_rsp_data, w_redirect_pc, w_id_instr, w_id_pc;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
  );

  instruction_fetch #(.RESET_PC(W_RESET_PC), .DEPTH(4)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_addr(w_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .id_valid(w_id_valid), .id_ready(w_id_ready), .id_instr(w_id_instr), .id_pc(w_id_pc)
  );

  int checks, errors;

  // Model: program counter, live outstanding addresses, stale count, decode queue.
  logic [31:0] m_pc;
  logic [31:0] m_out[$];
  int          m_drop;
  logic [31:0] m_buf_pc[$];
  logic [31:0] m_buf_ins[$];
  logic [31:0] next_cons;
  logic [31:0] mem_q[$];

  logic        w_pend;
  logic [31:0] w_pend_addr, w_exp_pc;
  int          w_seen;
  logic [31:0] w_first[3];

  logic        s_req_valid, s_id_valid;
  logic [31:0] s_addr, s_id_pc;
  int          req_count, pop_total;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_out.delete();
    m_drop = 0;
    m_buf_pc.delete();
    m_buf_ins.delete();
    next_cons = 32'h0;
    mem_q.delete();
    w_pend = 1'b0;
    w_exp_pc = W_RESET_PC;
  endtask

  task automatic cycle(input bit idr, input bit reqr, input bit rsp_ok, input bit redir,
                       input logic [31:0] rpc);
    bit pop, exp_req, rsp;
    @(negedge clk);
    rst = hold_rst;
    id_ready = idr;
    imem_req_ready = reqr;
    redirect_valid = redir;
    redirect_pc = rpc;
    rsp = rsp_ok && !rst && (mem_q.size() > 0);
    imem_rsp_valid = rsp;
    imem_rsp_data = rsp ? word_of(mem_q[0]) : 32'h0;
    w_rsp_valid = w_pend && !rst;
    w_rsp_data = word_of(w_pend_addr);
    #1;
    s_req_valid = imem_req_valid;
    s_addr = imem_addr;
    s_id_valid = id_valid;
    s_id_pc = id_pc;
    if (rst) begin
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_id_valid", id_valid, 0);
      check("rst_wrap_id_valid", w_id_valid, 0);
      model_reset();
    end else begin
      assert (!rsp || (m_out.size() + m_drop) > 0)
        else $error("memory response with no outstanding request");
      pop = (m_buf_pc.size() > 0) && idr;
      exp_req = (m_drop == 0) && !redir && (m_out.size() + m_buf_pc.size() - int'(pop) < DEPTH);
      check("req_valid", imem_req_valid, exp_req);
      if (exp_req) check("imem_addr", imem_addr, {m_pc[31:2], 2'b00});
      check("id_valid", id_valid, m_buf_pc.size() > 0);
      if (m_buf_pc.size() > 0) begin
        check("id_pc", id_pc, m_buf_pc[0]);
        check("id_instr", id_instr, m_buf_ins[0]);
      end
      // Consumed stream must be sequential from the last redirect/reset target.
      if (id_valid && idr) begin
        check("pop_order", id_pc, next_cons);
        check("pop_instr", id_instr, word_of(next_cons));
        next_cons += 32'd4;
        pop_total++;
      end
      if (pop) begin
        void'(m_buf_pc.pop_front());
        void'(m_buf_ins.pop_front());
      end
      if (redir) begin
        if (m_drop == 0) begin
          m_drop = m_out.size() - int'(rsp);
          m_out.delete();
          m_buf_pc.delete();
          m_buf_ins.delete();
        end else if (rsp) begin
          m_drop--;
        end
        m_pc = {rpc[31:2], 2'b00};
        next_cons = {rpc[31:2], 2'b00};
      end else if (m_drop > 0) begin
        if (rsp) m_drop--;
      end else begin
        if (rsp) begin
          m_buf_pc.push_back(m_out[0]);
          m_buf_ins.push_back(word_of(m_out[0]));
          void'(m_out.pop_front());
        end
        if (exp_req && reqr) begin
          m_out.push_back({m_pc[31:2], 2'b00});
          m_pc += 32'd4;
        end
      end
      if (rsp) void'(mem_q.pop_front());
      if (imem_req_valid && reqr) begin
        mem_q.push_back(imem_addr);
        req_count++;
      end
      if (w_id_valid) begin
        check("wrap_id_pc", w_id_pc, w_exp_pc);
        check("wrap_id_instr", w_id_instr, word_of(w_exp_pc));
        if (w_seen < 3) w_first[w_seen] = w_id_pc;
        w_seen++;
        w_exp_pc += 32'd4;
      end
      w_pend = w_req_valid;
      w_pend_addr = w_addr;
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    hold_rst = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    hold_rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_stream[4];
    bit got;
    int pops_before;
    exp_stream = '{32'h0, 32'h4, 32'h8, 32'hC};
    checks = 0; errors = 0; req_count = 0; pop_total = 0; w_seen = 0;
    rst = 1'b1; hold_rst = 1'b1;
    id_ready = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0;
    w_req_ready = 1'b1; w_redirect_valid = 1'b0; w_redirect_pc = '0; w_id_ready = 1'b1;
    w_rsp_valid = 1'b0; w_rsp_data = '0;
    model_reset();

    // Reset state and streaming start-up.
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("rst_addr", s_addr, 32'h0);
    hold_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (i == 0) begin
        check("first_req_valid", s_req_valid, 1);
        check("first_req_addr", s_addr, 32'h0);
      end
      if (i < 2) check("stream_idle", s_id_valid, 0);
      else if (i < 6) begin
        check("stream_valid", s_id_valid, 1);
        check("stream_pc", s_id_pc, exp_stream[i-2]);
      end
    end

    // Decode backpressure.
    do_reset();
    req_count = 0;
    repeat (8) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("bp_req_count", req_count, DEPTH);
    check("bp_req_valid", s_req_valid, 0);
    check("bp_id_valid", s_id_valid, 1);
    check("bp_id_pc", s_id_pc, 32'h0);
    pops_before = pop_total;
    repeat (12) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("bp_resume", (pop_total - pops_before) >= 5, 1);

    // Redirect with two outstanding requests.
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("credit_stop", s_req_valid, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0103);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("flush_no_req1", s_req_valid, 0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("flush_no_req2", s_req_valid, 0);
    check("flush_id_valid", s_id_valid, 0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("post_flush_req", s_req_valid, 1);
    check("post_flush_addr", s_addr, 32'h0000_0100);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (s_id_valid) got = 1'b1;
    end
    check("redir_first_pc", got ? s_id_pc : 32'hDEAD_BEEF, 32'h0000_0100);

    // Redirect coinciding with a decode pop and a response.
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    pops_before = pop_total;
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    check("corner_id_valid", s_id_valid, 1);
    check("corner_id_pc", s_id_pc, 32'h0);
    check("corner_pop_once", pop_total - pops_before, 1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("corner_cleared", s_id_valid, 0);
    check("corner_no_flush", s_req_valid, 1);
    check("corner_addr", s_addr, 32'h0000_0200);

    // Asynchronous reset between clock edges.
    repeat (6) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    #2;
    check("pre_async_id_valid", id_valid, 1);
    rst = 1'b1;
    hold_rst = 1'b1;
    #1;
    check("async_req_valid", imem_req_valid, 0);
    check("async_id_valid", id_valid, 0);
    check("async_wrap_id_valid", w_id_valid, 0);
    repeat (2) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    hold_rst = 1'b0;
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("async_first_req", s_req_valid, 1);
    check("async_first_addr", s_addr, 32'h0);

    // Randomized traffic with occasional redirects and resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) do_reset();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 99) < 4, $urandom);
    end

    // Wrapping reset PC.
    check("wrap_seen", w_seen >= 3, 1);
    check("wrap_pc0", w_first[0], 32'hFFFF_FFF8);
    check("wrap_pc1", w_first[1], 32'hFFFF_FFFC);
    check("wrap_pc2", w_first[2], 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: combined limit on outstanding requests plus buffered instructions; legal range 2..4.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts request.
REQ-007 imem_addr  output  32  word-aligned fetch address.
REQ-008 imem_rsp_valid  input  1  response valid; in request order; cannot be back-pressured.
REQ-009 imem_rsp_data  input  32  fetched instruction word.
REQ-010 redirect_valid  input  1  control-flow change (branch/jal taken).
REQ-011 redirect_pc  input  32  new fetch target.
REQ-012 id_valid  output  1  decode-side instruction valid.
REQ-013 id_ready  input  1  decode stage accepts.
REQ-014 id_instr  output  32  instruction to decode and immediate generation.
REQ-015 id_pc  output  32  address of id_instr.

Function
REQ-016 Request handshake: a request transfers when imem_req_valid and imem_req_ready are both 1; pc then advances by 4, wrapping 32'hFFFF_FFFC to 32'h0.
REQ-017 imem_req_valid shall be 1 only in state FETCH, with no redirect this cycle and (outstanding + buffered) < DEPTH.
REQ-018 imem_addr shall equal pc with bits[1:0] = 0, and shall stay stable while imem_req_valid=1 and imem_req_ready=0.
REQ-019 Each accepted request's address shall be queued; the matching response shall be paired with it in order.
REQ-020 A non-stale response shall enter the buffer in the cycle after imem_rsp_valid; the credit rule (REQ-017) guarantees space, so overflow is impossible.
REQ-021 id_valid shall be 1 iff the buffer is non-empty; id_instr/id_pc shall be the buffer head; the head pops on id_valid and id_ready.
REQ-022 Latency: request accepted in cycle N with response in cycle N+1 gives id_valid in N+2.
REQ-023 Simultaneous push and pop on a full buffer shall succeed.
REQ-024 Redirect has priority over all other events: the buffer is cleared, pc <= {redirect_pc[31:2], 2'b00}, no request is issued, and id_valid=0 from the next cycle.
REQ-025 A pop handshake in the redirect cycle shall still complete.
REQ-026 On redirect, drop_cnt <= outstanding requests not answered in that cycle; the next drop_cnt responses shall be discarded.
REQ-027 FSM states: FETCH and FLUSH. FETCH->FLUSH on redirect with drop_cnt>0. FLUSH->FETCH when the last stale response arrives.
REQ-028 In FLUSH: no requests; a further redirect updates pc only, stays in FLUSH, and leaves drop_cnt unchanged.
REQ-029 A response with no outstanding request is illegal; the bench shall flag it via assertion.

Reset
REQ-030 While rst=1: imem_req_valid=0, id_valid=0, pc=RESET_PC, buffer and address queue empty, outstanding=0, drop_cnt=0, state FETCH.
REQ-031 The first request shall be presented in the first cycle after rst deasserts.
REQ-032 Reset mid-operation shall discard all in-flight state; the memory side shall also be reset, so no stale response follows.

Structure
REQ-033 The shared core package shall hold the FSM state enum (FETCH, FLUSH), the constants XLEN=32 and PC_STEP=4, and the shared RESET_PC default.
REQ-034 Sub-module fetch_buffer: a DEPTH-entry synchronous FIFO of {pc, instr} with push, pop, count, and clear.
REQ-035 The address queue shall reuse fetch_buffer with instr unused, or an equivalent DEPTH-entry queue.

Verification
REQ-036 Streaming: reset, imem_req_ready=1, memory answers next cycle, id_ready=1 -> id_pc = 0,4,8,12 on consecutive cycles from the 3rd cycle after reset.
REQ-037 Backpressure: id_ready=0 -> at most DEPTH requests issued, imem_req_valid=0 thereafter, id_pc held at 0; release id_ready -> resumes in order with no loss or duplicate.
REQ-038 Redirect with 2 outstanding requests, redirect_pc=32'h0000_0103 -> both stale responses dropped, state FLUSH for 2 responses, next id_pc = 32'h0000_0100.
REQ-039 Wrap-around: RESET_PC=32'hFFFF_FFF8 -> id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-040 Corner: redirect coincides with an id pop and a response in the same cycle -> the popped instruction counts once, the response counts as non-stale-dropped (drop_cnt excludes it), and the fetched word is discarded.
REQ-041 Async reset asserted mid-stream between clock edges -> outputs go to reset values immediately; the first request after release is at RESET_PC.
